// File: rtl/trace_pkt_buffer_if.sv
// rtl/trace_pkt_buffer_if.sv - trace packet capture / readout handshake bundle
interface trace_pkt_buffer_if;
    logic        TPE;
    logic [31:0] TP;
    logic        rd_rdy;
    logic        rd_vld;
    logic [31:0] rd_data;

    modport master (
        output TPE,
        output TP,
        output rd_rdy,
        input  rd_vld,
        input  rd_data
    );

    modport slave (
        input  TPE,
        input  TP,
        input  rd_rdy,
        output rd_vld,
        output rd_data
    );
endinterface

// File: rtl/trace_pkt_buffer.sv
// rtl/trace_pkt_buffer.sv - circular trace FIFO with overflow tracking and halt/post-trigger freeze
// Optional overflow marker word enabled by TRACE_OVF_MARKER_EN.
module trace_pkt_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int POST  = 4
) (
    input  logic                 clk,
    input  logic                 MRST,
    trace_pkt_buffer_if.slave    bus,
    input  logic                 en,
    input  logic                 halt,
    input  logic                 flush,
    output logic [AW:0]          count,
    output logic                 ovf,
    output logic [15:0]          drop_cnt,
    output logic                 frozen
);

    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_POST  = (AW+1)'(POST);
    localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] P_ONE   = (AW)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_POSTCAP = 2'd2,
        S_FROZEN  = 2'd3
    } state_t;

    state_t         r_state;
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [AW:0]    r_count;
    logic [AW:0]    r_post;
    logic           r_ovf;
    logic           r_frozen;
    logic           r_halt_q;
    logic [15:0]    r_drop_cnt;
    logic [31:0]    r_mem [DEPTH];

    logic           w_capturing;
    logic           w_cap;
    logic           w_full;
    logic           w_rd_vld;
    logic           w_pop;
    logic           w_push_tp;
    logic           w_push;
    logic           w_drop;
    logic           w_halt_edge;
    logic [AW:0]    w_post_nxt;
    logic [31:0]    w_wdata;

    assign w_capturing = (r_state == S_RUN) || (r_state == S_POSTCAP);
    assign w_cap       = bus.TPE && w_capturing;
    assign w_full      = (r_count == C_DEPTH);
    assign w_rd_vld    = (r_count != '0);
    assign w_pop       = w_rd_vld && bus.rd_rdy;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign w_push_tp   = w_cap && (!w_full || w_pop);
    assign w_drop      = w_cap && w_full && !w_pop;
    assign w_halt_edge = halt && !r_halt_q;
    assign w_post_nxt  = r_post + C_ONE;

`ifdef TRACE_OVF_MARKER_EN
    logic r_mark_pend;
    logic w_mark;

    // Marker only fills idle TPE slots so live trace words are never displaced.
    assign w_mark  = r_mark_pend && w_capturing && !bus.TPE && !w_full;
    assign w_push  = w_push_tp || w_mark;
    assign w_wdata = bus.TPE ? bus.TP : {16'hDEAD, r_drop_cnt};

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            r_mark_pend <= 1'b0;
        end else if (flush) begin
            r_mark_pend <= 1'b0;
        end else if (w_drop) begin
            r_mark_pend <= 1'b1;
        end else if (w_mark) begin
            r_mark_pend <= 1'b0;
        end
    end
`else
    assign w_push  = w_push_tp;
    assign w_wdata = bus.TP;
`endif

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wptr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + P_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + P_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_ONE;
                2'b01:   r_count <= r_count - C_ONE;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) begin
                    r_drop_cnt <= r_drop_cnt + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge MRST) begin
        if (!MRST) begin
            r_state  <= S_IDLE;
            r_post   <= '0;
            r_frozen <= 1'b0;
            r_halt_q <= 1'b0;
        end else begin
            r_halt_q <= halt;
            if (flush) begin
                r_state  <= S_IDLE;
                r_post   <= '0;
                r_frozen <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (en) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (!en) begin
                            r_state <= S_IDLE;
                        end else if (w_halt_edge) begin
                            if (C_POST == '0) begin
                                r_state  <= S_FROZEN;
                                r_frozen <= 1'b1;
                            end else begin
                                r_state <= S_POSTCAP;
                                r_post  <= '0;
                            end
                        end
                    end
                    S_POSTCAP: begin
                        if (!en) begin
                            r_state <= S_IDLE;
                            r_post  <= '0;
                        end else if (w_push) begin
                            // Dropped words never reach here, so only stored words count.
                            r_post <= w_post_nxt;
                            if (w_post_nxt == C_POST) begin
                                r_state  <= S_FROZEN;
                                r_frozen <= 1'b1;
                            end
                        end
                    end
                    S_FROZEN: begin
                        r_state <= S_FROZEN;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rd_vld  = w_rd_vld;
    assign bus.rd_data = w_rd_vld ? r_mem[r_rptr] : 32'h0;
    assign count       = r_count;
    assign ovf         = r_ovf;
    assign drop_cnt    = r_drop_cnt;
    assign frozen      = r_frozen;

endmodule

// File: doc/trace_pkt_buffer.md
Name: trace_pkt_buffer

Overview:
- Downstream consumer of the AES debug block's trace-packet stream (TP/TPE).
- Captures every 32-bit trace word into a circular FIFO and drains it to the debug wrapper or SPI link over a valid/ready handshake.
- Tracks overflow with a sticky flag and a drop counter.
- Supports a halt-with-post-trigger freeze, so the events around a trigger stay in the buffer for readout.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 4.
- AW, 4, pointer width; must equal log2(DEPTH).
- POST, 4, words still captured after halt before freezing; range 0..DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- MRST  input  1  asynchronous active-low reset.
- TPE  input  1  trace packet enable; TP is valid this cycle.
- TP  input  32  trace packet word.
- en  input  1  capture enable, sourced from debug config.
- halt  input  1  trigger; one-cycle pulse or level, rising edge sampled.
- flush  input  1  synchronous clear of buffer and status.
- rd_rdy  input  1  consumer ready.
- rd_vld  output  1  rd_data valid (FIFO not empty).
- rd_data  output  32  head-of-FIFO word (first-word fall-through).
- count  output  AW+1  current occupancy, 0..DEPTH.
- ovf  output  1  sticky overflow flag.
- drop_cnt  output  16  number of dropped words; saturates at 16'hFFFF.
- frozen  output  1  high in FROZEN state.

Behaviour:
- Reset (MRST=0, async): wptr, rptr, count, drop_cnt, post counter = 0; ovf=0; state=IDLE; rd_vld=0; rd_data=0; frozen=0. Memory contents are don't-care.
- States:
  - IDLE: no capture. Goes to RUN when en=1.
  - RUN: capture. Goes to IDLE when en=0. Goes to POSTCAP on a halt rising edge (halt=1 and registered halt=0).
  - POSTCAP: capture continues; post counter increments per accepted push. Goes to FROZEN when post counter reaches POST. With POST=0, a halt edge goes straight from RUN to FROZEN.
  - FROZEN: no capture; reads still allowed. Leaves only on flush, to IDLE.
  - en=0 in POSTCAP goes to IDLE.
- cap = TPE && state in {RUN, POSTCAP}.
- pop = rd_vld && rd_rdy.
- push = cap && (count<DEPTH || pop): pushing when full is accepted if a pop happens in the same cycle.
- push: mem[wptr]<=TP; wptr wraps modulo DEPTH.
- pop: rptr wraps modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both.
- Drop: cap && count==DEPTH && !pop. Sets ovf=1 and increments drop_cnt, saturating at 16'hFFFF. A dropped word does not advance the post counter.
- rd_vld = (count!=0). rd_data = mem[rptr], combinational read of registered storage. A word is visible one cycle after its push (write latency 1).
- Pop on an empty FIFO is impossible by construction; an rd_rdy-only cycle is ignored.
- flush (highest priority, synchronous): clears pointers, count, ovf, drop_cnt and post counter; state to IDLE. Any push/pop in that cycle is discarded.
- halt edges in IDLE or FROZEN are ignored. halt held high does not retrigger.
- Asserting reset mid-burst discards the FIFO immediately; a partial 4-word key/text burst is not completed.

Optional Feature:
- Macro TRACE_OVF_MARKER_EN.
- Defined:
  - After an overflow, once a slot is free, state is RUN or POSTCAP, and TPE=0, one marker word {16'hDEAD, drop_cnt} is pushed.
  - A pending-marker bit is set on the first drop and cleared when the marker is written or on flush.
  - The marker counts toward POST in POSTCAP.
  - TPE=1 always has priority over the marker.
- Undefined: no marker; the pending bit is absent; behaviour is exactly as above.

Test Plan:
- Reset/idle: MRST low then high, en=0, TPE pulses with TP=32'h1234 -> count=0, rd_vld=0, drop_cnt=0.
- Basic: en=1, push 32'hA0..32'hA3 on 4 consecutive TPE cycles, rd_rdy=0 -> count=4. Then rd_rdy=1 -> rd_data A0,A1,A2,A3 on consecutive cycles; rd_vld falls after A3.
- Overflow: DEPTH=16, push 20 words with rd_rdy=0 -> count=16, ovf=1, drop_cnt=4, words 0..15 read back in order.
- Full with simultaneous push/pop: FIFO full, TPE=1 and rd_rdy=1 in the same cycle -> count stays 16, no drop, new word becomes the tail.
- Halt: POST=4, RUN, halt pulse, then 6 TPE words -> 4 accepted, frozen=1, remaining 2 ignored and not counted as drops. Flush -> IDLE, count=0, ovf=0.
- Marker (TRACE_OVF_MARKER_EN): overflow with 3 drops, pop 1, TPE=0 -> next entry is 32'hDEAD0003.
